// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  // Counter width for a given iteration count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(DIV_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtract for one restoring-division step: x - y in WIDTH+1 bits,
// built as x + ~y + 1 with a ripple carry chain. y is zero-extended, so the
// result sign bit is reported as borrow and only the low WIDTH bits are kept.
module div_trial_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Invert-plus-carry-in ripple; the top stage adds ~0 = 1 for the extension bit.
  always_comb begin
    logic [WIDTH:0] c;
    c      = '0;
    diff   = '0;
    borrow = 1'b0;
    c[0]   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = x[i] ^ ~y[i] ^ c[i];
      c[i+1]  = (x[i] & ~y[i]) | (x[i] & c[i]) | (~y[i] & c[i]);
    end
    borrow = ~(x[WIDTH] ^ c[WIDTH]);
  end

endmodule

// File: rtl/seq_divider_16bit.sv
// Iterative restoring unsigned divider, one quotient bit per enabled clock.
// Optional macro SEQ_DIVIDER_DIV0_ERR_EN adds an err output and a fast
// divide-by-zero exit; without it a zero divisor runs the full iteration count.
module seq_divider_16bit
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
  output logic             err,
`endif
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] prem_q;  // partial remainder
  logic [WIDTH-1:0] dvd_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] dvd_next;

  assign shifted = {prem_q, dvd_q[WIDTH-1]};

  div_trial_sub #(
    .WIDTH(WIDTH)
  ) u_trial (
    .x     (shifted),
    .y     (dvs_q),
    .diff  (trial_diff),
    .borrow(trial_borrow)
  );

  // Restore on borrow: keep the shifted remainder and shift in a zero quotient bit.
  assign prem_next = trial_borrow ? shifted[WIDTH-1:0] : trial_diff;
  assign dvd_next  = {dvd_q[WIDTH-2:0], ~trial_borrow};

  // Control FSM, working registers and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      quot    <= '0;
      rem     <= '0;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
      err     <= 1'b0;
`endif
    end else if (!en) begin
      // Stall: everything holds, but a done pulse never stretches.
      done <= 1'b0;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
      err  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
      err  <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dvd_q   <= a;
            dvs_q   <= b;
            prem_q  <= '0;
            cnt_q   <= CntLast;
            busy    <= 1'b1;
            state_q <= ST_CALC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
          // Zero divisor leaves on the first CALC edge, before any shift of dvd_q.
          if (dvs_q == '0) begin
            quot    <= '1;
            rem     <= dvd_q;
            err     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_DONE;
          end else
`endif
          begin
            prem_q <= prem_next;
            dvd_q  <= dvd_next;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              quot    <= dvd_next;
              rem     <= prem_next;
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= ST_DONE;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Self-checking bench for seq_divider_16bit: scoreboard of expected results,
// compared on every done pulse, plus directed latency/stall/reset scenarios.
module tb_seq_divider_16bit;

  localparam int unsigned W = 16;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
  logic         err;
`endif

  seq_divider_16bit #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
    .err  (err),
`endif
    .quot (quot),
    .rem  (rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           st_edge;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc      = 0;
  int           n_checks = 0;
  int           n_pass   = 0;
  int           busy_cnt = 0;
  int           done_cnt = 0;
  logic [W-1:0] last_q   = '0;
  logic [W-1:0] last_r   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, expv, cyc);
  endtask

  function automatic int nom_lat(input logic [W-1:0] bb);
    return (ErrEn && bb == '0) ? 1 : 16;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard side: every done pulse pops one expected operation.
  always @(posedge clk) begin
    exp_t         e;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    #1;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (e.b == '0) begin
          eq = '1;
          er = e.a;
        end else begin
          eq = e.a / e.b;
          er = e.a % e.b;
          check("invariant", 32'(quot) * 32'(e.b) + 32'(rem), 32'(e.a));
        end
        check("quot", 32'(quot), 32'(eq));
        check("rem", 32'(rem), 32'(er));
        check("latency", 32'(cyc - e.st_edge), 32'(e.lat));
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
        check("err", 32'(err), 32'(e.b == '0));
`endif
        last_q = eq;
        last_r = er;
      end
    end
  end

  // Drive one start at the current negedge; the next posedge is the start edge.
  task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input int lat);
    exp_t e;
    a         = aa;
    b         = bb;
    start     = 1'b1;
    e.a       = aa;
    e.b       = bb;
    e.st_edge = cyc + 1;
    e.lat     = lat;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [W-1:0] ra, rb;
    rst   = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // 100 / 7: latency, busy length, single-cycle done.
    busy_cnt = 0;
    start_op(16'd100, 16'd7, 16);
    wait_done("t1");
    check("t1_busy_cycles", 32'(busy_cnt), 32'd16);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // 0xFFFF / 1, then a new start accepted in the done cycle.
    @(negedge clk);
    start_op(16'hFFFF, 16'd1, 16);
    repeat (16) @(negedge clk);
    check("t2_in_done_cycle", 32'(done), 32'd1);
    start_op(16'd5, 16'd9, 16);
    wait_done("t2");

    // Divide by zero.
    @(negedge clk);
    start_op(16'd1000, 16'd0, nom_lat(16'd0));
    wait_done("t3");

    // 200 / 3 with a start pulse while busy and a 5-cycle enable stall.
    @(negedge clk);
    start_op(16'd200, 16'd3, 21);
    repeat (3) @(negedge clk);
    a     = 16'd1;
    b     = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_hold_quot", 32'(quot), 32'(last_q));
    check("t4_hold_rem", 32'(rem), 32'(last_r));
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_stall_busy", 32'(busy), 32'd1);
    en = 1'b1;
    wait_done("t4");

    // Reset on the 8th CALC cycle of 500 / 7 aborts without a done pulse.
    @(negedge clk);
    start_op(16'd500, 16'd7, 16);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_done", 32'(done), 32'd0);
    check("t5_abort_quot", 32'(quot), 32'd0);
    check("t5_abort_rem", 32'(rem), 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_done", 32'(done_cnt), 32'(d0));
    start_op(16'd500, 16'd7, 16);
    wait_done("t5");

    // Random sweep with nonzero divisors, alternating wide and small ranges.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = W'($urandom);
      rb = (i % 2 == 0) ? W'($urandom_range(1, 65535)) : W'($urandom_range(1, 15));
      start_op(ra, rb, 16);
      wait_done("rnd");
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider_16bit.md
Name: seq_divider_16bit

Overview:
- Iterative restoring unsigned divider. It is the inverse-direction companion to the team's registered add/subtract datapath.
- Takes a dividend and a divisor on a start strobe. Produces one quotient bit per enabled clock.
- Presents registered quotient and remainder with a one-cycle done pulse.
- Sits beside the 16-bit adder/register blocks in the lab datapath. Reuses the same two's-complement subtract (invert operand, carry-in 1) for each trial step.

Parameters:
- WIDTH, 16, operand, quotient and remainder width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- en  input  1  clock enable. When 0, all state, counters and outputs freeze, except that done is forced to 0.
- start  input  1  request a division. Sampled only when en=1.
- a  input  WIDTH  dividend, captured on an accepted start.
- b  input  WIDTH  divisor, captured on an accepted start.
- busy  output  1  high while iterating.
- done  output  1  single-cycle pulse when the result is valid.
- quot  output  WIDTH  registered quotient.
- rem  output  WIDTH  registered remainder.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, quot=0, rem=0; internal working registers and counter cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 && en=1 → load working dividend/quotient = a, divisor = b, partial remainder = 0, counter = WIDTH-1.
  - Go to CALC; busy=1 from the next cycle.
- CALC, each enabled edge:
  - Shift {partial remainder, working dividend} left one bit.
  - Trial = shifted remainder − divisor, computed in WIDTH+1 bits.
  - No borrow (trial MSB=0): remainder = trial and the new quotient LSB = 1. Borrow: remainder keeps the shifted value and the quotient LSB = 0.
  - Counter decrements. The edge that processes counter=0 moves to DONE and writes quot and rem from the working registers.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - start=1 in the DONE cycle is accepted exactly as in IDLE and goes straight to CALC.
- Latency: with en held high, done is high in the cycle after WIDTH CALC edges following the start edge. For WIDTH=16 that is 17 edges from the start edge to the done cycle.
- start while busy=1 is ignored. No queueing, no error.
- quot/rem hold the last result through all later CALC cycles. They change only on the transition into DONE.
- en=0 mid-CALC stalls with no lost or duplicated iteration. Latency grows by the number of stalled cycles.
- Divide by zero with the macro absent: the natural algorithm result stands, quot = all ones and rem = a. Latency is normal.
- Reset asserted mid-operation aborts immediately. No done pulse; outputs return to 0.
- Inputs a/b are don't-care after capture.

Optional Feature:
- Macro: SEQ_DIVIDER_DIV0_ERR_EN.
- When defined:
  - Adds output port err (1 bit, reset 0).
  - An accepted start with b=0 skips CALC and moves to DONE on the next edge, with quot = all ones, rem = a and err=1 for the done cycle.
  - err is 0 on every other done pulse.
- When undefined: no err port. Divide by zero runs the full WIDTH iterations as described under Behaviour.

Decomposition:
- Shared package seq_divider_pkg:
  - DIV_WIDTH default (16).
  - State encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - Counter width constant CNT_W = clog2(DIV_WIDTH).
- One natural sub-module, div_trial_sub: combinational WIDTH+1-bit subtract giving difference and borrow. Built as an invert-plus-carry-in ripple, consistent with the existing add/subtract datapath.
- Top module holds the FSM, counter and registers.

Test Plan:
- a=100, b=7, en=1 → done after 17 edges; quot=14, rem=2; busy high for 16 cycles.
- a=0xFFFF, b=1 → quot=0xFFFF, rem=0. Then, in the done cycle, start with a=5, b=9 → accepted back-to-back; quot=0, rem=5.
- a=1000, b=0:
  - macro undefined → quot=0xFFFF, rem=1000 at normal latency.
  - macro defined → done 2 edges after start, err=1.
- a=200, b=3 with en dropped low for 5 cycles mid-CALC; also pulse start while busy → result quot=66, rem=2; done at 17+5 edges; the extra start has no effect.
- Reset asserted on the 8th CALC cycle of a=500, b=7 → all outputs 0 immediately, no done pulse. After release, a=500, b=7 → quot=71, rem=3.
- Random sweep of 1000 (a, b≠0) pairs → quot*b + rem == a and rem < b for every done pulse.
